// File: rtl/sprite_compositor.sv
// Pixel-stage mixer: aligns sprite flags to ROM pixels, keys, prioritises,
// expands to 8-bit VGA channels and counts per-frame sprite overlap.
module sprite_compositor #(
    parameter int COLOR_DEPTH = 8,
    parameter logic [COLOR_DEPTH-1:0] TRANSPARENT = 8'hE3,
    parameter int ALIGN_DELAY = 1,
    parameter int H_TOTAL = 800,
    parameter int V_TOTAL = 525,
    parameter int CNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [9:0]             hcount,
    input  logic [9:0]             vcount,
    input  logic                   active,
    input  logic [COLOR_DEPTH-1:0] p1_color,
    input  logic                   p1_active,
    input  logic [COLOR_DEPTH-1:0] p2_color,
    input  logic                   p2_active,
    input  logic [COLOR_DEPTH-1:0] bg_color,
    input  logic                   p1_on_top,
    output logic [7:0]             vga_r,
    output logic [7:0]             vga_g,
    output logic [7:0]             vga_b,
    output logic                   collision,
    output logic [CNT_WIDTH-1:0]   overlap_count,
    output logic                   frame_done
);

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic a1, a2, av;

    generate
        if (ALIGN_DELAY == 0) begin : g_nodly
            assign a1 = p1_active;
            assign a2 = p2_active;
            assign av = active;
        end else begin : g_dly
            // Each stage carries {av, a2, a1} together
            logic [2:0] dly_q [ALIGN_DELAY];
            logic [2:0] dly_d [ALIGN_DELAY];

            always_comb begin
                dly_d[0] = {active, p2_active, p1_active};
                for (int i = 1; i < ALIGN_DELAY; i++) begin
                    dly_d[i] = dly_q[i-1];
                end
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    for (int i = 0; i < ALIGN_DELAY; i++) begin
                        dly_q[i] <= '0;
                    end
                end else begin
                    for (int i = 0; i < ALIGN_DELAY; i++) begin
                        dly_q[i] <= dly_d[i];
                    end
                end
            end

            assign {av, a2, a1} = dly_q[ALIGN_DELAY-1];
        end
    endgenerate

    logic                   o1, o2, ovl;
    logic [COLOR_DEPTH-1:0] pix;
    logic                   boundary;

    assign o1       = a1 & (p1_color != TRANSPARENT);
    assign o2       = a2 & (p2_color != TRANSPARENT);
    assign ovl      = o1 & o2 & av;
    assign boundary = (hcount == H_LAST) && (vcount == V_LAST);

    always_comb begin
        pix = bg_color;
        if (!av) begin
            pix = '0;
        end else if (o1 && o2) begin
            pix = p1_on_top ? p1_color : p2_color;
        end else if (o1) begin
            pix = p1_color;
        end else if (o2) begin
            pix = p2_color;
        end
    end

    logic [7:0]           r_q, r_d, g_q, g_d, b_q, b_d;
    logic [CNT_WIDTH-1:0] acc_q, acc_d, cnt_q, cnt_d, acc_inc;
    logic                 coll_q, coll_d, done_q, done_d;

    always_comb begin
        r_d     = {pix[7:5], pix[7:5], pix[7:6]};
        g_d     = {pix[4:2], pix[4:2], pix[4:3]};
        b_d     = {pix[1:0], pix[1:0], pix[1:0], pix[1:0]};
        acc_inc = (ovl && acc_q != CNT_MAX) ? acc_q + 1'b1 : acc_q;
        acc_d   = acc_inc;
        cnt_d   = cnt_q;
        coll_d  = coll_q;
        done_d  = 1'b0;
        if (boundary) begin
            cnt_d  = acc_inc;
            coll_d = (acc_inc != '0);
            done_d = 1'b1;
            acc_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q    <= '0;
            g_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            coll_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            r_q    <= r_d;
            g_q    <= g_d;
            b_q    <= b_d;
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            coll_q <= coll_d;
            done_q <= done_d;
        end
    end

    assign vga_r         = r_q;
    assign vga_g         = g_q;
    assign vga_b         = b_q;
    assign collision     = coll_q;
    assign overlap_count = cnt_q;
    assign frame_done    = done_q;

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor: alignment, keying, priority,
// expansion, overlap counting, saturation and mid-frame reset.
module tb_sprite_compositor;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  hcount, vcount;
    logic        active;
    logic [7:0]  p1_color, p2_color, bg_color;
    logic        p1_active, p2_active, p1_on_top;
    logic [7:0]  vga_r, vga_g, vga_b;
    logic        collision;
    logic [15:0] overlap_count;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    sprite_compositor dut (
        .clk(clk), .reset(reset),
        .hcount(hcount), .vcount(vcount), .active(active),
        .p1_color(p1_color), .p1_active(p1_active),
        .p2_color(p2_color), .p2_active(p2_active),
        .bg_color(bg_color), .p1_on_top(p1_on_top),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .collision(collision), .overlap_count(overlap_count),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_rgb(input string tag, input logic [23:0] exp);
        check(tag, {8'h0, vga_r, vga_g, vga_b}, {8'h0, exp});
    endtask

    task automatic check_frame(input string tag, input logic done,
                               input logic coll, input logic [15:0] cnt);
        check({tag, "_done"}, {31'h0, frame_done}, {31'h0, done});
        check({tag, "_coll"}, {31'h0, collision}, {31'h0, coll});
        check({tag, "_cnt"}, {16'h0, overlap_count}, {16'h0, cnt});
    endtask

    task automatic idle();
        hcount = 10'd0; vcount = 10'd0; active = 1'b1;
        p1_active = 1'b0; p2_active = 1'b0;
        p1_color = 8'h00; p2_color = 8'h00; bg_color = 8'h00;
        p1_on_top = 1'b1;
    endtask

    task automatic boundary_tick();
        hcount = 10'd799; vcount = 10'd524;
        tick();
        hcount = 10'd0; vcount = 10'd0;
    endtask

    task automatic randomize_inputs();
        hcount = 10'($urandom); vcount = 10'($urandom);
        active = 1'($urandom);
        p1_color = 8'($urandom); p2_color = 8'($urandom);
        bg_color = 8'($urandom);
        p1_active = 1'($urandom); p2_active = 1'($urandom);
        p1_on_top = 1'($urandom);
    endtask

    initial begin
        reset = 1'b0;
        randomize_inputs();
        #1;
        for (int i = 0; i < 5; i++) begin
            tick();
            randomize_inputs();
        end
        check_rgb("rst_rgb", 24'h000000);
        check_frame("rst", 1'b0, 1'b0, 16'd0);

        idle();
        reset = 1'b1;
        tick();
        tick();
        check_rgb("idle_bg", 24'h000000);

        // p1 pulse: flag at N, pixel at N+1, output visible after N+2
        p1_active = 1'b1;
        tick();
        p1_active = 1'b0;
        p1_color = 8'hE0;
        tick();
        check_rgb("p1_pulse", 24'hFF0000);
        p1_color = 8'h00;
        tick();
        check_rgb("p1_after", 24'h000000);

        // transparent key shows background
        p1_active = 1'b1;
        p1_color = 8'hE3;
        bg_color = 8'h1C;
        tick();
        tick();
        check_rgb("key_bg", 24'h00FF00);
        bg_color = 8'h03;
        tick();
        check_rgb("bg_blue", 24'h0000FF);
        idle();
        tick();
        tick();
        check_frame("midframe0", 1'b0, 1'b0, 16'd0);

        // 10-pixel overlap, priority flips halfway
        p1_active = 1'b1; p2_active = 1'b1;
        p1_color = 8'hE0; p2_color = 8'h03;
        for (int i = 0; i < 10; i++) begin
            p1_on_top = (i < 5);
            tick();
            if (i >= 1) check_rgb(i < 5 ? "ovl_red" : "ovl_blue",
                                  i < 5 ? 24'hFF0000 : 24'h0000FF);
        end
        p1_active = 1'b0; p2_active = 1'b0;
        tick();
        tick();
        check_frame("pre_bnd", 1'b0, 1'b0, 16'd0);
        boundary_tick();
        check_frame("frame1", 1'b1, 1'b1, 16'd10);
        tick();
        check_frame("frame1_hold", 1'b0, 1'b1, 16'd10);

        // frame with no overlap
        p1_active = 1'b1; p1_color = 8'hFF;
        for (int i = 0; i < 5; i++) tick();
        check_rgb("white", 24'hFFFFFF);
        check_frame("frame2_mid", 1'b0, 1'b1, 16'd10);
        p1_active = 1'b0;
        tick();
        boundary_tick();
        check_frame("frame2", 1'b1, 1'b0, 16'd0);
        tick();
        check_frame("frame2_hold", 1'b0, 1'b0, 16'd0);

        // active low blanks output even with opaque sprite
        p1_active = 1'b1; active = 1'b0;
        tick();
        tick();
        check_rgb("blank", 24'h000000);
        idle();
        tick();

        // saturation
        p1_active = 1'b1; p2_active = 1'b1;
        p1_color = 8'hE0; p2_color = 8'h03;
        for (int i = 0; i < 70000; i++) tick();
        p1_active = 1'b0; p2_active = 1'b0;
        tick();
        tick();
        boundary_tick();
        check_frame("sat", 1'b1, 1'b1, 16'hFFFF);

        // mid-frame reset discards partial count
        p1_active = 1'b1; p2_active = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        reset = 1'b0;
        #1;
        check_rgb("rst2_rgb", 24'h000000);
        check_frame("rst2", 1'b0, 1'b0, 16'd0);
        for (int i = 0; i < 5; i++) begin
            randomize_inputs();
            tick();
        end
        idle();
        p1_color = 8'hE0; p2_color = 8'h03;
        reset = 1'b1;
        p1_active = 1'b1; p2_active = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        p1_active = 1'b0; p2_active = 1'b0;
        tick();
        tick();
        boundary_tick();
        check_frame("after_rst", 1'b1, 1'b1, 16'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sprite_compositor.md
Name: sprite_compositor

Overview:
- Pixel-stage mixer directly downstream of the two per-player sprite renderers.
- Aligns each renderer's active flag to its clocked-ROM pixel, keys out the transparent colour and resolves player/player/background priority.
- Expands the packed colour to 8-bit VGA channels.
- Accumulates a per-frame count of overlapping opaque pixels, latched at frame end for the hit-detection logic.

Parameters:
- COLOR_DEPTH, 8, packed pixel width, format RRRGGGBB (3/3/2)
- TRANSPARENT, 8'hE3, colour key treated as "no pixel"
- ALIGN_DELAY, 1, cycles player_active flags are delayed to match ROM read latency; legal range 0..3
- H_TOTAL, 800, hcount period
- V_TOTAL, 525, vcount period
- CNT_WIDTH, 16, width of overlap counter

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous active-low reset
- hcount  in  10  horizontal counter from VGA timing
- vcount  in  10  vertical counter from VGA timing
- active  in  1  visible-area enable from VGA timing, aligned to hcount
- p1_color  in  COLOR_DEPTH  player 1 ROM pixel
- p1_active  in  1  player 1 sprite window flag, undelayed
- p2_color  in  COLOR_DEPTH  player 2 ROM pixel
- p2_active  in  1  player 2 sprite window flag, undelayed
- bg_color  in  COLOR_DEPTH  background pixel, already aligned to ROM outputs
- p1_on_top  in  1  1: player 1 wins overlap; 0: player 2 wins
- vga_r / vga_g / vga_b  out  8 each  registered output channels
- collision  out  1  previous frame had at least one overlap pixel
- overlap_count  out  CNT_WIDTH  overlap pixels in previous frame
- frame_done  out  1  one-cycle pulse when collision/overlap_count update

Behaviour:
- Reset (async, reset==0): all outputs 0; delay pipelines and accumulator cleared. Reset mid-frame discards the partial count; the first frame_done after release reports only pixels seen since release.
- Alignment: p1_active, p2_active and active each pass through an ALIGN_DELAY-stage shift register (a1, a2, av). ALIGN_DELAY=0 means no delay stage is inserted.
- Opaque flags: o1 = a1 & (p1_color != TRANSPARENT); o2 is formed the same way from a2 and p2_color.
- Selection:
  - o1&o2: p1_on_top ? p1 : p2
  - only o1: p1
  - only o2: p2
  - neither: bg_color
  - av==0: forces 0 regardless of the above.
- Expansion (bit replication):
  - r = {R,R,R[2:1]}
  - g = {G,G,G[2:1]}
  - b = {B,B,B,B}
  - Example: 8'hFF -> FF/FF/FF; 8'h03 -> 00/00/FF.
- Latency: vga_* is registered; 1 cycle after the aligned colour/flags, i.e. ALIGN_DELAY+1 cycles after the raw *_active inputs.
- Overlap accumulator:
  - Increments on each cycle with o1 & o2 & av.
  - Saturates at 2^CNT_WIDTH-1; no wrap.
- Frame boundary is the cycle with hcount==H_TOTAL-1 and vcount==V_TOTAL-1, using the undelayed counters. On the following clock edge:
  - overlap_count <= accumulator value including that cycle's increment;
  - collision <= (that value != 0);
  - frame_done <= 1 for exactly one cycle;
  - accumulator <= 0.
- Overlap pixels still in the delay pipeline at the boundary (up to ALIGN_DELAY pixels) count toward the next frame. This is acceptable because the boundary lies in blanking, where av==0.
- collision and overlap_count hold their values between boundaries.
- p1_on_top may change on any cycle; it is sampled combinationally with the aligned data, with no extra delay.

Test Plan:
- Reset held low 5 cycles with random inputs -> vga_*=0, collision=0, overlap_count=0, frame_done=0; release -> outputs follow the pipeline after ALIGN_DELAY+1 cycles.
- ALIGN_DELAY=1, p1_active pulsed at cycle N with p1_color=8'hE0 at N+1, active=1, bg=8'h00 -> vga_r=FF, g=00, b=00 at N+2 only; bg 00/00/00 elsewhere.
- p1_color=8'hE3 (key) with p1_active=1, p2 inactive, bg_color=8'h1C -> output shows bg (00/FF/00), no overlap counted.
- 10-pixel overlap of opaque p1=8'hE0 and p2=8'h03: p1_on_top=1 gives red, p1_on_top=0 gives blue -> at frame boundary overlap_count=10, collision=1, frame_done single-cycle pulse.
- Next frame with no overlap -> overlap_count=0 and collision=0 after its boundary; values held steady mid-frame.
- Force 70000 overlap cycles (CNT_WIDTH=16) -> overlap_count=65535, no wrap; reset asserted mid-frame then released -> accumulator restarts from 0.
